// File: rtl/pipe_generator.sv
// Scrolling pipe field for the 16x16 Flappy Bird LED display: columns shift left on
// each counted step, a pipe with a random gap enters on the right every SPACING columns.
module pipe_generator #(
  parameter int WIDTH    = 16,
  parameter int HEIGHT   = 16,
  parameter int GAP      = 4,
  parameter int SPACING  = 6,
  parameter int BIRD_COL = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      enable,
  input  logic                      step,
  input  logic [3:0]                rand_in,
  output logic [HEIGHT*WIDTH-1:0]   frame,
  output logic [HEIGHT-1:0]         bird_col_pixels,
  output logic [7:0]                score,
  output logic                      score_pulse
);

  localparam int CNT_W = (SPACING > 1) ? $clog2(SPACING) : 1;
  localparam int GAP_MAX_TOP = HEIGHT - GAP;
  localparam logic [HEIGHT-1:0] GAP_ONES = HEIGHT'((64'd1 << GAP) - 64'd1);

  logic [HEIGHT-1:0] r_col [WIDTH];
  logic [WIDTH-1:0]  r_is_pipe;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_score;
  logic              r_score_pulse;

  logic              w_step;
  logic [31:0]       w_rand;
  logic [31:0]       w_gap_top;
  logic [HEIGHT-1:0] w_pipe_word;

  // Out-of-range random values fold back to the top so every gap fits on screen.
  always_comb begin
    w_rand      = 32'(rand_in);
    w_gap_top   = (w_rand <= 32'(GAP_MAX_TOP)) ? w_rand : w_rand - 32'(GAP_MAX_TOP + 1);
    w_pipe_word = ~(GAP_ONES << w_gap_top);
    w_step      = enable & step;
  end

  always_ff @(posedge clock) begin
    r_score_pulse <= 1'b0;
    if (reset || clear) begin
      // NOTE: the column array is reset on purpose; a restart must show a blank field.
      for (int c = 0; c < WIDTH; c++) r_col[c] <= '0;
      r_is_pipe <= '0;
      r_cnt     <= '0;
      r_score   <= '0;
    end else if (w_step) begin
      for (int c = 0; c < WIDTH - 1; c++) begin
        r_col[c]     <= r_col[c+1];
        r_is_pipe[c] <= r_is_pipe[c+1];
      end
      if (r_cnt == '0) begin
        r_col[WIDTH-1]     <= w_pipe_word;
        r_is_pipe[WIDTH-1] <= 1'b1;
        r_cnt              <= CNT_W'(SPACING - 1);
      end else begin
        r_col[WIDTH-1]     <= '0;
        r_is_pipe[WIDTH-1] <= 1'b0;
        r_cnt              <= r_cnt - 1'b1;
      end
      // The pipe at the bird's column before this shift is the one being passed.
      if (r_is_pipe[BIRD_COL]) begin
        r_score_pulse <= 1'b1;
        if (r_score != 8'hFF) r_score <= r_score + 8'd1;
      end
    end
  end

  for (genvar c = 0; c < WIDTH; c++) begin : g_frame
    assign frame[c*HEIGHT +: HEIGHT] = r_col[c];
  end

  assign bird_col_pixels = r_col[BIRD_COL];
  assign score           = r_score;
  assign score_pulse     = r_score_pulse;

endmodule

// File: tb/tb_pipe_generator.sv
// Directed bench for pipe_generator: table of gap placements plus hand-written
// sequences for spacing, scoring, enable/clear, mid-burst reset and saturation.
module tb_pipe_generator;

  logic         clock = 1'b0;
  logic         reset, clear, enable, step;
  logic [3:0]   rand_in;
  logic [255:0] frame;
  logic [15:0]  bird_col_pixels;
  logic [7:0]   score;
  logic         score_pulse;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  pipe_generator dut (
    .clock           (clock),
    .reset           (reset),
    .clear           (clear),
    .enable          (enable),
    .step            (step),
    .rand_in         (rand_in),
    .frame           (frame),
    .bird_col_pixels (bird_col_pixels),
    .score           (score),
    .score_pulse     (score_pulse)
  );

  typedef struct {
    logic        use_clear;
    logic [3:0]  rnd;
    logic [15:0] word;
  } gap_vec_t;

  gap_vec_t vecs [7];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_step(input logic [3:0] r);
    step    = 1'b1;
    rand_in = r;
    cyc();
    step    = 1'b0;
  endtask

  task automatic hard_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  function automatic logic [255:0] place(input int c, input logic [15:0] w);
    return 256'(w) << (c * 16);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses;
    reset = 1'b1; clear = 1'b0; enable = 1'b0; step = 1'b0; rand_in = 4'd0;
    cyc();
    cyc();
    reset = 1'b0;
    check("reset_frame", frame, '0);
    check("reset_bird", 256'(bird_col_pixels), '0);
    check("reset_score", 256'(score), '0);
    check("reset_pulse", 256'(score_pulse), '0);
    enable = 1'b1;

    // Gap placement, including the folded-back rand values 13..15.
    vecs = '{
      '{1'b0, 4'd5,  16'hFE1F},
      '{1'b0, 4'd14, 16'hFFE1},
      '{1'b1, 4'd12, 16'h0FFF},
      '{1'b0, 4'd0,  16'hFFF0},
      '{1'b1, 4'd13, 16'hFFF0},
      '{1'b0, 4'd15, 16'hFFC3},
      '{1'b1, 4'd1,  16'hFFE1}
    };
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].use_clear) begin
        clear = 1'b1;
        cyc();
        clear = 1'b0;
      end else begin
        hard_reset();
      end
      do_step(vecs[i].rnd);
      check($sformatf("gap_frame_rand%0d", vecs[i].rnd), frame, place(15, vecs[i].word));
      check($sformatf("gap_score_rand%0d", vecs[i].rnd), 256'(score), '0);
    end

    // Spacing: rand_in changes every step but only steps 1, 7, 13 sample it.
    hard_reset();
    for (int i = 1; i <= 13; i++) do_step(4'(i));
    check("spacing_frame", frame, place(3, 16'hFFE1) | place(9, 16'hF87F) | place(15, 16'hFFF0));
    check("spacing_bird", 256'(bird_col_pixels), 256'(16'hFFE1));
    check("spacing_score", 256'(score), '0);
    check("spacing_pulse", 256'(score_pulse), '0);

    // Scoring on step 14.
    do_step(4'd0);
    check("score_after14", 256'(score), 256'(8'd1));
    check("pulse_after14", 256'(score_pulse), 256'(1'b1));
    check("bird_after14", 256'(bird_col_pixels), '0);
    check("frame_after14", frame, place(2, 16'hFFE1) | place(8, 16'hF87F) | place(14, 16'hFFF0));
    cyc();
    check("pulse_one_cycle", 256'(score_pulse), '0);
    check("score_hold", 256'(score), 256'(8'd1));

    // Disabled step pulses change nothing, including the spacing counter.
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step = 1'b1;
      cyc();
      step = 1'b0;
      cyc();
    end
    check("disabled_frame", frame, place(2, 16'hFFE1) | place(8, 16'hF87F) | place(14, 16'hFFF0));
    check("disabled_score", 256'(score), 256'(8'd1));
    check("disabled_pulse", 256'(score_pulse), '0);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) do_step(4'd9);
    check("resume_no_pipe", frame, place(4, 16'hF87F) | place(10, 16'hFFF0));
    do_step(4'd9);
    check("resume_pipe", frame, place(3, 16'hF87F) | place(9, 16'hFFF0) | place(15, 16'hE1FF));
    do_step(4'd9);
    check("resume_score", 256'(score), 256'(8'd2));
    check("resume_pulse", 256'(score_pulse), 256'(1'b1));

    // Clear wins over a simultaneous step; the next step inserts a pipe.
    clear = 1'b1;
    step  = 1'b1;
    cyc();
    clear = 1'b0;
    step  = 1'b0;
    check("clear_frame", frame, '0);
    check("clear_score", 256'(score), '0);
    check("clear_pulse", 256'(score_pulse), '0);
    do_step(4'd5);
    check("clear_first_pipe", frame, place(15, 16'hFE1F));

    // Reset during a burst, on the very step that would score.
    for (int i = 0; i < 12; i++) do_step(4'd5);
    check("burst_bird", 256'(bird_col_pixels), 256'(16'hFE1F));
    reset = 1'b1;
    step  = 1'b1;
    cyc();
    reset = 1'b0;
    step  = 1'b0;
    check("midreset_frame", frame, '0);
    check("midreset_bird", 256'(bird_col_pixels), '0);
    check("midreset_score", 256'(score), '0);
    check("midreset_pulse", 256'(score_pulse), '0);

    // Saturation: 1900 back-to-back steps pass pipes at steps 14, 20, ... 1898.
    hard_reset();
    pulses  = 0;
    step    = 1'b1;
    rand_in = 4'd3;
    for (int i = 0; i < 1900; i++) begin
      cyc();
      if (score_pulse) pulses++;
    end
    step = 1'b0;
    check("sat_score", 256'(score), 256'(8'd255));
    check("sat_pulses", 256'(pulses), 256'(315));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_generator.md
Name: pipe_generator

Overview:
- Consumes the 4-bit pseudo-random value from the LFSR stage and builds the scrolling pipe field for the Flappy Bird 16x16 LED display.
- On each scroll strobe, shifts every column one position left and inserts a new rightmost column: either a pipe with a randomly placed gap or an empty column.
- Exports the full red-LED frame, the column at the bird's position for collision checking, and a saturating score.

Parameters:
- WIDTH, 16, number of display columns (column 0 leftmost, WIDTH-1 rightmost)
- HEIGHT, 16, number of display rows (row 0 = bit 0 of a column word)
- GAP, 4, height of the opening in each pipe, in rows
- SPACING, 6, column pitch between consecutive pipes
- BIRD_COL, 3, column the bird occupies

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  game restart; same effect as reset, synchronous
- enable  in  1  game running; when low, step is ignored
- step  in  1  one-cycle scroll strobe
- rand_in  in  4  current LFSR output
- frame  out  HEIGHT*WIDTH  bit [c*HEIGHT + r] = pipe pixel at column c, row r
- bird_col_pixels  out  HEIGHT  column BIRD_COL of frame, for the collision check
- score  out  8  pipes passed; saturates at 255
- score_pulse  out  1  high for one cycle when score increments

Behaviour:
- Clock and reset: one clock, named clock. Reset is synchronous and active-high, named reset.
- Reset or clear (either high at a clock edge):
  - frame = 0, all is_pipe flags = 0
  - score = 0, score_pulse = 0
  - spacing counter = 0
  - Clear has priority over step and enable.
- Per-column state: a HEIGHT-bit pixel word plus a 1-bit is_pipe flag for every column.
- Step handling: a step counts only when enable=1, reset=0 and clear=0 at the clock edge. Otherwise the frame, flags, counter and score hold, and score_pulse = 0.
- On a counted step, at that same edge:
  - Column c takes column c+1 for c = 0..WIDTH-2. Column 0's old contents are discarded.
  - If the spacing counter is 0:
    - Column WIDTH-1 becomes a pipe and its is_pipe flag is set to 1.
    - gap_top = rand_in when rand_in <= HEIGHT-GAP; otherwise gap_top = rand_in - (HEIGHT-GAP+1).
    - Pixel r = 0 for gap_top <= r < gap_top+GAP, and 1 for all other rows.
    - The spacing counter reloads to SPACING-1.
  - Otherwise, column WIDTH-1 = 0, its is_pipe flag = 0, and the counter decrements by 1.
- Score:
  - On a counted step where column BIRD_COL held is_pipe=1 before the shift, score increments by 1 (if below 255).
  - score_pulse = 1 in the following cycle only. It is registered at the same edge as the increment.
  - At 255, score holds and score_pulse is still asserted.
- Latency: all outputs are registered. frame, bird_col_pixels and score reflect a step one clock edge after step is sampled.
- bird_col_pixels is always equal to frame column BIRD_COL; it has no extra delay.
- rand_in is sampled only at edges where a pipe is inserted. It is used combinationally, with no extra register.
- Back-to-back steps (step high on consecutive cycles) are each handled fully. No step is dropped.
- First pipe after reset or clear: the counter starts at 0, so the first counted step inserts a pipe.

Test Plan:
- Gap placement, low rand: reset, rand_in=5, one step -> column 15 = 16'hFE1F (rows 5..8 open), columns 0..14 = 0, score=0.
- Gap placement, wrapped rand: reset, rand_in=14, one step -> column 15 = 16'hFFE1 (gap_top=1). Repeat with rand_in=12 -> 16'h0FFF.
- Spacing: reset, enable=1, 13 consecutive steps -> pipes inserted at steps 1, 7 and 13. After step 13, is_pipe is set at columns 3, 9 and 15 only.
- Scoring: from reset, 14 steps -> after step 13 bird_col_pixels equals the first pipe word, and score=0. After step 14, score=1, score_pulse high for exactly one cycle, and bird_col_pixels=0.
- Enable and clear:
  - enable=0 with 5 step pulses mid-game -> frame, score and counter unchanged.
  - clear and step asserted together -> frame=0, score=0, and the next counted step inserts a pipe.
- Reset mid-operation and saturation:
  - Assert reset in the middle of a step burst -> all outputs are 0 on the next cycle.
  - Force 300 pipes past the bird -> score stops at 255.
